// File: rtl/neuron_mac_accumulator.sv
// Multiply-accumulate front end for the activation stage: sums N_INPUTS fixed-point
// products, adds a bias, saturates to 32 bits and hands the result over with a start pulse.
module neuron_mac_accumulator #(
    parameter int N_INPUTS  = 8,
    parameter int FRAC_BITS = 16,
    parameter int ACC_W     = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [31:0] in_weight,
    input  logic [31:0] bias,
    output logic [31:0] act_x,
    output logic        act_start,
    input  logic        act_done,
    output logic        busy,
    output logic        sat_flag
);

    // state   | meaning
    // S_IDLE  | accumulator cleared, waiting for the first pair of a neuron
    // S_ACCUM | collecting the remaining pairs
    // S_BIAS  | bias added, saturated result registered onto act_x
    // S_ISSUE | act_start high, act_x valid
    // S_WAIT  | act_x held until the activation stage reports act_done
    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_BIAS,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam logic [7:0] LAST_M1 = 8'(N_INPUTS - 1);

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [7:0]         count_q, count_d;
    logic        [31:0]        act_x_q, act_x_d;
    logic                      act_start_q, act_start_d;
    logic                      sat_flag_q, sat_flag_d;

    logic signed [ACC_W-1:0]   prod_acc;
    logic signed [ACC_W-1:0]   bias_acc;
    logic signed [ACC_W-1:0]   biased;
    logic                      in_range;
    logic        [31:0]        sat_x;
    logic                      accept;

    assign in_ready = (state_q == S_IDLE) || (state_q == S_ACCUM);
    assign accept   = in_valid && in_ready;

    // Full 64-bit product, arithmetic shift floors toward -inf before resizing.
    assign prod_acc = ACC_W'((64'($signed(in_data)) * 64'($signed(in_weight))) >>> FRAC_BITS);
    assign bias_acc = ACC_W'($signed(bias));
    assign biased   = acc_q + bias_acc;

    // The sum fits in 32 bits only when every bit from 31 upward is a sign copy.
    assign in_range = (&biased[ACC_W-1:31]) || !(|biased[ACC_W-1:31]);

    always_comb begin
        sat_x = biased[31:0];
        if (!in_range) begin
            sat_x = biased[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        act_x_d     = act_x_q;
        act_start_d = 1'b0;
        sat_flag_d  = sat_flag_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = prod_acc;
                    count_d = 8'd1;
                    state_d = (N_INPUTS == 1) ? S_BIAS : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    acc_d   = acc_q + prod_acc;
                    count_d = count_q + 8'd1;
                    if (count_q == LAST_M1) begin
                        state_d = S_BIAS;
                    end
                end
            end
            S_BIAS: begin
                // Registering the result here lets act_x and act_start appear together.
                acc_d       = biased;
                act_x_d     = sat_x;
                sat_flag_d  = !in_range;
                act_start_d = 1'b1;
                state_d     = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (act_done) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            act_x_q     <= '0;
            act_start_q <= 1'b0;
            sat_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            act_x_q     <= act_x_d;
            act_start_q <= act_start_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    assign act_x     = act_x_q;
    assign act_start = act_start_q;
    assign sat_flag  = sat_flag_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Directed and randomized checks of neuron_mac_accumulator against an arithmetic reference model.
// Both instances use a 64-bit accumulator so full-scale pairs saturate instead of wrapping.
module tb_neuron_mac_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data, in_weight, bias;

    logic        in_valid4, in_ready4, act_start4, act_done4, busy4, sat4;
    logic [31:0] act_x4;
    logic        in_valid1, in_ready1, act_start1, act_done1, busy1, sat1;
    logic [31:0] act_x1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] obs_x;
    logic        obs_sat;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    always #5 clk = ~clk;

    neuron_mac_accumulator #(.N_INPUTS(4), .FRAC_BITS(16), .ACC_W(64)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data), .in_weight(in_weight), .bias(bias), .act_x(act_x4),
        .act_start(act_start4), .act_done(act_done4), .busy(busy4), .sat_flag(sat4)
    );

    neuron_mac_accumulator #(.N_INPUTS(1), .FRAC_BITS(16), .ACC_W(64)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data), .in_weight(in_weight), .bias(bias), .act_x(act_x1),
        .act_start(act_start1), .act_done(act_done1), .busy(busy1), .sat_flag(sat1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact real-number semantics: floor each scaled product, add bias, clamp to 32 bits.
    function automatic void model(input logic [31:0] d[4], input logic [31:0] w[4], input int n,
                                  input logic [31:0] b, output logic [31:0] x, output logic s);
        longint acc = 0;
        for (int i = 0; i < n; i++) begin
            acc += (longint'($signed(d[i])) * longint'($signed(w[i]))) >>> 16;
        end
        acc += longint'($signed(b));
        if (acc > MAXV) begin
            x = 32'h7FFF_FFFF; s = 1'b1;
        end else if (acc < MINV) begin
            x = 32'h8000_0000; s = 1'b1;
        end else begin
            x = acc[31:0];     s = 1'b0;
        end
    endfunction

    task automatic run4(input logic [31:0] d[4], input logic [31:0] w[4], input logic [31:0] b,
                        input bit toggle, input bit hold);
        logic [31:0] ex;
        logic        es;
        logic        rdy;
        int          idx = 0;
        int          cyc = 0;
        model(d, w, 4, b, ex, es);
        bias = b;
        while (idx < 4 && cyc < 200) begin
            in_valid4 = toggle ? (cyc % 2 == 0) : 1'b1;
            if (in_valid4) begin
                in_data = d[idx]; in_weight = w[idx];
            end else begin
                in_data = $urandom; in_weight = $urandom;
            end
            rdy = in_ready4;
            @(posedge clk); #1;
            if (in_valid4 && rdy) idx++;
            cyc++;
        end
        chk("accept_budget", 64'(idx), 64'd4);
        in_valid4 = hold;
        in_data   = $urandom;
        in_weight = $urandom;
        chk("bias_no_start", 64'(act_start4), 64'd0);
        chk("bias_not_ready", 64'(in_ready4), 64'd0);
        @(posedge clk); #1;
        chk("issue_start", 64'(act_start4), 64'd1);
        chk("issue_act_x", 64'(act_x4), 64'(ex));
        chk("issue_sat", 64'(sat4), 64'(es));
        chk("issue_not_ready", 64'(in_ready4), 64'd0);
        obs_x   = act_x4;
        obs_sat = sat4;
        @(posedge clk); #1;
        chk("start_one_cycle", 64'(act_start4), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("wait_not_ready", 64'(in_ready4), 64'd0);
        chk("wait_busy", 64'(busy4), 64'd1);
        chk("wait_hold_x", 64'(act_x4), 64'(ex));
        act_done4 = 1'b1;
        @(posedge clk); #1;
        act_done4 = 1'b0;
        in_valid4 = 1'b0;
        chk("done_idle", 64'(busy4), 64'd0);
        chk("done_ready", 64'(in_ready4), 64'd1);
        chk("done_hold_x", 64'(act_x4), 64'(ex));
    endtask

    initial begin
        logic [31:0] da [4];
        logic [31:0] wa [4];
        logic [31:0] tmp;
        logic        seen;

        reset = 1'b0;
        in_data = '0; in_weight = '0; bias = '0;
        in_valid4 = 1'b0; act_done4 = 1'b0;
        in_valid1 = 1'b0; act_done1 = 1'b0;
        #12;
        chk("rst_act_x", 64'(act_x4), 64'd0);
        chk("rst_start", 64'(act_start4), 64'd0);
        chk("rst_sat", 64'(sat4), 64'd0);
        chk("rst_busy", 64'(busy4), 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // 1.0 * 0.5 four times, zero bias
        da = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        wa = '{32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000};
        run4(da, wa, 32'h0, 1'b0, 1'b0);
        chk("t1_const", 64'(obs_x), 64'h0002_0000);
        chk("t1_sat", 64'(obs_sat), 64'd0);

        // mixed signs with a negative bias
        da = '{32'hFFFE_8000, 32'h0001_0000, 32'h0000_0000, 32'h0000_4000};
        wa = '{32'h0002_0000, 32'h0001_0000, $urandom, 32'h0004_0000};
        run4(da, wa, 32'hFFFF_0000, 1'b0, 1'b0);
        chk("t2_const", 64'(obs_x), 64'hFFFE_0000);

        // full-scale positive and negative saturation
        da = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000};
        wa = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000};
        run4(da, wa, 32'h0, 1'b0, 1'b0);
        chk("t3_pos_const", 64'(obs_x), 64'h7FFF_FFFF);
        chk("t3_pos_sat", 64'(obs_sat), 64'd1);
        wa = '{32'h8001_0000, 32'h8001_0000, 32'h8001_0000, 32'h8001_0000};
        run4(da, wa, 32'h0, 1'b0, 1'b0);
        chk("t3_neg_const", 64'(obs_x), 64'h8000_0000);
        chk("t3_neg_sat", 64'(obs_sat), 64'd1);

        // gapped valid, valid held through WAIT, random values
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 4; i++) begin
                tmp = $urandom;
                da[i] = (n % 2 == 1) ? {{12{tmp[19]}}, tmp[19:0]} : tmp;
                tmp = $urandom;
                wa[i] = (n % 2 == 1) ? {{12{tmp[19]}}, tmp[19:0]} : tmp;
            end
            run4(da, wa, $urandom, (n < 3), 1'b1);
        end

        // asynchronous reset after two of four pairs
        in_valid4 = 1'b1; in_data = 32'h0003_0000; in_weight = 32'h0002_0000;
        @(posedge clk); #1;
        in_data = 32'h0001_0000; in_weight = 32'h0005_0000;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        chk("t5_busy_before", 64'(busy4), 64'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("t5_act_x", 64'(act_x4), 64'd0);
        chk("t5_start", 64'(act_start4), 64'd0);
        chk("t5_sat", 64'(sat4), 64'd0);
        chk("t5_busy", 64'(busy4), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (act_start4) seen = 1'b1;
        end
        chk("t5_no_start", 64'(seen), 64'd0);
        da = '{32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0001_8000};
        wa = '{32'h0001_0000, 32'h0003_0000, 32'h0004_0000, 32'h0002_0000};
        run4(da, wa, 32'h0000_4000, 1'b0, 1'b0);

        // single-input neuron, early act_done ignored
        bias = 32'h0001_0000;
        in_data = 32'h0002_0000; in_weight = 32'h0003_0000;
        in_valid1 = 1'b1;
        chk("t6_ready", 64'(in_ready1), 64'd1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        chk("t6_bias_busy", 64'(busy1), 64'd1);
        chk("t6_bias_nostart", 64'(act_start1), 64'd0);
        @(posedge clk); #1;
        chk("t6_start", 64'(act_start1), 64'd1);
        chk("t6_act_x", 64'(act_x1), 64'h0007_0000);
        chk("t6_sat", 64'(sat1), 64'd0);
        act_done1 = 1'b1;
        @(posedge clk); #1;
        act_done1 = 1'b0;
        chk("t6_early_done_busy", 64'(busy1), 64'd1);
        chk("t6_start_low", 64'(act_start1), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_still_wait", 64'(busy1), 64'd1);
        chk("t6_hold_x", 64'(act_x1), 64'h0007_0000);
        act_done1 = 1'b1;
        @(posedge clk); #1;
        act_done1 = 1'b0;
        chk("t6_done_idle", 64'(busy1), 64'd0);
        chk("t6_done_ready", 64'(in_ready1), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
